stream_uart_tx: RTL and testbench

STREAM_UART_TX -- requirements
Module: stream_uart_tx

---
 rtl/stream_uart_tx_pkg.sv | 19 +
 rtl/stream_fifo.sv | 58 +++++
 rtl/stream_uart_tx.sv | 145 ++++++++++++++
 tb/tb_stream_uart_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_uart_tx_pkg.sv
// rtl/stream_uart_tx_pkg.sv - shared FSM states and default rates for the stream UART transmitter
package stream_uart_tx_pkg;

  localparam int DEFAULT_CLOCK_FREQUENCY = 100000000;
  localparam int DEFAULT_BAUD_RATE       = 115200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Integer truncation is intentional: each bit lasts floor(clk/baud) cycles.
  function automatic int baud_divider(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO with push/pop/full/empty/count, power-of-two depth
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflowing pushes and underflowing pops are ignored so nothing is overwritten.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_uart_tx.sv
// rtl/stream_uart_tx.sv - stream-fed 8N1 UART transmitter with FIFO, baud counter and frame FSM
module stream_uart_tx
  import stream_uart_tx_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
  parameter int BAUD_RATE       = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_data,
  input  logic        input_data_stb,
  output logic        input_data_ack,
  output logic        tx
);

  localparam int DIVIDER = baud_divider(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVIDER - 1);

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] baud_cnt, baud_next;
  logic [2:0]       bit_idx, idx_next;
  logic [7:0]       shift, shift_next;
  logic             tx_next;
  logic             ack_next;
  logic             baud_done;

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_data;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             unused_upper;

  assign unused_upper = ^input_data[31:8];
  assign fifo_push    = input_data_stb && input_data_ack && !fifo_full;
  assign baud_done    = (baud_cnt == BAUD_LAST);

  stream_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (input_data[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    idx_next   = bit_idx;
    shift_next = shift;
    tx_next    = tx;
    fifo_pop   = 1'b0;
    // Ack is a one-cycle pulse, so a transfer can happen at most every other edge.
    ack_next   = !input_data_ack && input_data_stb && (fifo_count < CW'(FIFO_DEPTH));

    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_data;
          baud_next  = '0;
          tx_next    = 1'b0;
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_next  = '0;
          idx_next   = 3'd0;
          tx_next    = shift[0];
          shift_next = {1'b0, shift[7:1]};
          state_next = ST_DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = ST_STOP;
          end else begin
            idx_next   = bit_idx + 3'd1;
            tx_next    = shift[0];
            shift_next = {1'b0, shift[7:1]};
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued frames have no idle gap.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_data;
            tx_next    = 1'b0;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      baud_cnt       <= '0;
      bit_idx        <= 3'd0;
      shift          <= 8'd0;
      tx             <= 1'b1;
      input_data_ack <= 1'b0;
    end else begin
      state          <= state_next;
      baud_cnt       <= baud_next;
      bit_idx        <= idx_next;
      shift          <= shift_next;
      tx             <= tx_next;
      input_data_ack <= ack_next;
    end
  end

endmodule

// File: tb/tb_stream_uart_tx.sv
// tb/tb_stream_uart_tx.sv - scoreboard bench: writes push expected bytes, a line monitor decodes frames
module tb_stream_uart_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int FRAME  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_data = 32'd0;
  logic        input_data_stb = 1'b0;
  logic        input_data_ack;
  logic        tx;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         frames_started = 0;
  int         frames_done = 0;

  bit         m_active = 0;
  int         m_cnt;
  int         m_bi;
  bit         m_err;
  logic [7:0] m_byte;
  logic [7:0] m_exp;
  int         m_start_cyc = 0;

  stream_uart_tx #(
    .CLOCK_FREQUENCY (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .input_data     (input_data),
    .input_data_stb (input_data_stb),
    .input_data_ack (input_data_ack),
    .tx             (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Line monitor: decodes each 100-cycle frame at negedges and scores it against the queue.
  always @(negedge clk) begin
    if (rst) begin
      m_active = 0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active    = 1;
        m_cnt       = 1;
        m_err       = 0;
        m_byte      = 8'd0;
        m_start_cyc = cyc;
        frames_started++;
        starts_q.push_back(cyc);
      end
    end else begin
      if (m_cnt < 10) begin
        if (tx !== 1'b0) m_err = 1;
      end else if (m_cnt < 90) begin
        m_bi = (m_cnt / 10) - 1;
        if (m_cnt % 10 == 0) m_byte[m_bi] = tx;
        else if (tx !== m_byte[m_bi]) m_err = 1;
      end else begin
        if (tx !== 1'b1) m_err = 1;
      end
      m_cnt++;
      if (m_cnt == FRAME) begin
        m_active = 0;
        frames_done++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected: got byte %02h with no frame expected", m_byte);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_byte !== m_exp || m_err) begin
            failures++;
            $display("FAIL frame_byte: got %02h framing_error=%0d, expected %02h framing_error=0",
                     m_byte, m_err, m_exp);
          end
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] w, input logic [7:0] e);
    bit got;
    @(negedge clk);
    input_data     = w;
    input_data_stb = 1'b1;
    got = 0;
    for (int t = 0; t < 2000 && !got; t++) begin
      @(negedge clk);
      if (input_data_ack) got = 1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no ack for %08h, expected ack within 2000 cycles", w);
      input_data_stb = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1 input_data_stb = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string name);
    for (int t = 0; t < 3000 && frames_done < n; t++) @(negedge clk);
    check_eq(name, frames_done, n);
  endtask

  function automatic logic [31:0] mkword(input int i);
    return {8'(i), 16'hBEEF, 8'h40 + 8'(i)};
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n0, accepted, acc60, base_cyc, target;
    bit idle_bad, acc60_taken, got;

    // Reset for three cycles, then the line must stay quiet.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("reset_tx", tx, 1);
    check_eq("reset_ack", input_data_ack, 0);
    base = frames_started;
    idle_bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || input_data_ack !== 1'b0) idle_bad = 1;
    end
    check_eq("idle_quiet", idle_bad, 0);
    check_eq("idle_no_frame", frames_started, base);

    // Single word: tx falls one edge after the write edge.
    send(32'h0000_00A5, 8'hA5);
    @(negedge clk);
    check_eq("tx_high_on_write_edge", tx, 1);
    @(negedge clk);
    check_eq("tx_fall_latency", tx, 0);
    wait_frames(1, "frame_a5_done");

    // Upper bits must be ignored.
    send(32'hFFFF_FF3C, 8'h3C);
    wait_frames(2, "frame_3c_done");

    // Back-to-back frames must abut with no idle gap.
    n0 = starts_q.size();
    send(32'h0000_0011, 8'h11);
    send(32'h0000_0022, 8'h22);
    send(32'h0000_0033, 8'h33);
    wait_frames(5, "frames_b2b_done");
    if (starts_q.size() >= n0 + 3) begin
      check_eq("b2b_spacing_1", starts_q[n0+1] - starts_q[n0], FRAME);
      check_eq("b2b_spacing_2", starts_q[n0+2] - starts_q[n0+1], FRAME);
    end else begin
      check_eq("b2b_start_count", starts_q.size(), n0 + 3);
    end

    // Continuous strobe with 20 words: 17 accepted quickly, then one per frame.
    accepted = 0;
    acc60 = -1;
    acc60_taken = 0;
    @(negedge clk);
    base_cyc = cyc;
    input_data = mkword(0);
    input_data_stb = 1'b1;
    for (int t = 0; t < 6000 && accepted < 20; t++) begin
      @(negedge clk);
      if (!acc60_taken && cyc - base_cyc >= 60) begin
        acc60 = accepted;
        acc60_taken = 1;
      end
      if (input_data_ack) begin
        @(posedge clk);
        exp_q.push_back(8'h40 + 8'(accepted));
        accepted++;
        #1;
        if (accepted < 20) input_data = mkword(accepted);
        else input_data_stb = 1'b0;
      end
    end
    input_data_stb = 1'b0;
    check_eq("burst_accepted_at_60", acc60, 17);
    check_eq("burst_accepted_total", accepted, 20);
    wait_frames(25, "burst_frames_done");

    // Reset during data bit 4 with words queued: the rest is discarded.
    send(32'h0000_0061, 8'h61);
    send(32'h0000_0062, 8'h62);
    send(32'h0000_0063, 8'h63);
    send(32'h0000_0064, 8'h64);
    send(32'h0000_0065, 8'h65);
    target = m_start_cyc + 54;
    got = 0;
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      if (cyc >= target) got = 1;
    end
    check_eq("midframe_reached", got, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_eq("midframe_reset_tx", tx, 1);
    check_eq("midframe_reset_ack", input_data_ack, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    base = frames_started;
    n0 = frames_done;
    idle_bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) idle_bad = 1;
    end
    check_eq("after_reset_quiet", idle_bad, 0);
    check_eq("after_reset_no_frame", frames_started, base);
    send(32'h0000_005A, 8'h5A);
    wait_frames(n0 + 1, "after_reset_new_frame");

    // Reset while ack is high cancels the write.
    @(negedge clk);
    input_data = 32'h0000_0077;
    input_data_stb = 1'b1;
    got = 0;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      if (input_data_ack) got = 1;
    end
    check_eq("cancel_ack_seen", got, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    input_data_stb = 1'b0;
    base = frames_started;
    repeat (150) @(negedge clk);
    check_eq("cancel_no_frame", frames_started, base);
    check_eq("cancel_tx_idle", tx, 1);

    check_eq("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
